// File: rtl/braid_ctrl_pkg.sv
// Shared types and constants for the braid inlet sequencer.
// Command bundle, FSM state encoding and legality helper.
package braid_ctrl_pkg;

  localparam int N_INLETS = 8;
  localparam int IDX_W    = 3;
  localparam int DUR_W    = 8;

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    SETTLE,
    DONE
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] inlet;
    logic [DUR_W-1:0] dur;
  } cmd_t;

  function automatic logic cmd_legal(input cmd_t c);
    return (c.dur != '0) && (int'(c.inlet) < N_INLETS);
  endfunction

endpackage

// File: rtl/braid_cmd_fifo.sv
// Small synchronous FIFO of dose commands.
// Flush empties it in one cycle and outranks push and pop.
module braid_cmd_fifo
  import braid_ctrl_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  cmd_t          wdata,
  output cmd_t          rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  cmd_t            mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        level <= level + LW'(1);
      end else if (do_pop && !do_push) begin
        level <= level - LW'(1);
      end
    end
  end

endmodule

// File: rtl/braid_inlet_sequencer.sv
// Valve sequencer feeding the 8-input mixer braid.
// One inlet open at a time, then a closed settle window.
module braid_inlet_sequencer
  import braid_ctrl_pkg::*;
#(
  parameter  int FIFO_DEPTH    = 4,
  parameter  int SETTLE_CYCLES = 16,
  localparam int LW = $clog2(FIFO_DEPTH) + 1,
  localparam int SW = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IDX_W-1:0]    cmd_inlet,
  input  logic [DUR_W-1:0]    cmd_dur,
  input  logic                abort,
  output logic [N_INLETS-1:0] valve_open,
  output logic                busy,
  output logic                dose_done,
  output logic                cmd_err,
  output logic [LW-1:0]       fifo_level
);

  state_t              state;
  state_t              state_nx;
  logic [DUR_W-1:0]    dur_cnt;
  logic [DUR_W-1:0]    dur_nx;
  logic [SW-1:0]       set_cnt;
  logic [SW-1:0]       set_nx;
  logic [N_INLETS-1:0] valve_nx;
  logic                done_nx;
  logic                err_nx;
  logic                pop;
  logic                push;
  logic                full;
  logic                empty;
  cmd_t                head;
  cmd_t                wcmd;

  assign cmd_ready = !full && !abort;
  assign push      = cmd_valid && cmd_ready;
  assign wcmd      = '{inlet: cmd_inlet, dur: cmd_dur};

  braid_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (abort),
    .wdata (wcmd),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_comb begin
    state_nx = state;
    dur_nx   = dur_cnt;
    set_nx   = set_cnt;
    valve_nx = valve_open;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    pop      = 1'b0;
    if (abort) begin
      state_nx = IDLE;
      valve_nx = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            pop = 1'b1;
            if (!cmd_legal(head)) begin
              err_nx = 1'b1;
            end else begin
              state_nx = OPEN;
              dur_nx   = head.dur - DUR_W'(1);
              valve_nx = N_INLETS'(1) << head.inlet;
            end
          end
        end
        OPEN: begin
          if (dur_cnt == '0) begin
            state_nx = SETTLE;
            valve_nx = '0;
            set_nx   = SW'(SETTLE_CYCLES - 1);
          end else begin
            dur_nx = dur_cnt - DUR_W'(1);
          end
        end
        SETTLE: begin
          if (set_cnt == '0) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            set_nx = set_cnt - SW'(1);
          end
        end
        DONE: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dur_cnt    <= '0;
      set_cnt    <= '0;
      valve_open <= '0;
      busy       <= 1'b0;
      dose_done  <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      dur_cnt    <= dur_nx;
      set_cnt    <= set_nx;
      valve_open <= valve_nx;
      busy       <= (state_nx != IDLE);
      dose_done  <= done_nx;
      cmd_err    <= err_nx;
    end
  end

endmodule

// File: tb/tb_braid_inlet_sequencer.sv
// Directed self-checking bench for braid_inlet_sequencer.
// Each task drives one scenario and checks inline.
module tb_braid_inlet_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_inlet;
  logic [7:0] cmd_dur;
  logic       abort;
  logic [7:0] valve_open;
  logic       busy;
  logic       dose_done;
  logic       cmd_err;
  logic [2:0] fifo_level;

  int asserts;
  int fails;
  logic [7:0] prev_v;
  logic [7:0] seen [$];

  braid_inlet_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_inlet  (cmd_inlet),
    .cmd_dur    (cmd_dur),
    .abort      (abort),
    .valve_open (valve_open),
    .busy       (busy),
    .dose_done  (dose_done),
    .cmd_err    (cmd_err),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_cap();
    tick();
    if (valve_open != 8'h00 && prev_v == 8'h00) seen.push_back(valve_open);
    prev_v = valve_open;
  endtask

  task automatic drive(input logic [2:0] i, input logic [7:0] d);
    cmd_valid = 1'b1;
    cmd_inlet = i;
    cmd_dur   = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_inlet = '0;
    cmd_dur = '0;
    abort = 1'b0;
    #12;
    asserts++;
    if (valve_open !== 8'h00) begin
      fails++; $display("FAIL rst_valve got %h want 00", valve_open);
    end
    asserts++;
    if ({busy, dose_done, cmd_err} !== 3'b000) begin
      fails++; $display("FAIL rst_flags got %b want 000", {busy, dose_done, cmd_err});
    end
    asserts++;
    if (fifo_level !== 3'd0) begin
      fails++; $display("FAIL rst_level got %0d want 0", fifo_level);
    end
    asserts++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL rst_ready got %b want 1", cmd_ready);
    end
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_single_dose();
    logic [7:0] ev;
    drive(3'd3, 8'd5);
    tick();
    cmd_valid = 1'b0;
    asserts++;
    if (fifo_level !== 3'd1 || valve_open !== 8'h00) begin
      fails++; $display("FAIL t1_pop lvl %0d v %h want 1 00", fifo_level, valve_open);
    end
    for (int k = 1; k <= 22; k++) begin
      tick();
      ev = (k <= 5) ? 8'h08 : 8'h00;
      asserts++;
      if (valve_open !== ev) begin
        fails++; $display("FAIL t1_valve k=%0d got %h want %h", k, valve_open, ev);
      end
      asserts++;
      if (busy !== 1'b1 || dose_done !== (k == 22)) begin
        fails++; $display("FAIL t1_flags k=%0d busy %b done %b", k, busy, dose_done);
      end
    end
    tick();
    asserts++;
    if (busy !== 1'b0 || dose_done !== 1'b0) begin
      fails++; $display("FAIL t1_end busy %b done %b want 0 0", busy, dose_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [6];
    logic [2:0] ins [4];
    bit acc;
    exp_q = '{8'h04, 8'h01, 8'h02, 8'h10, 8'h20, 8'h40};
    ins = '{3'd0, 3'd1, 3'd4, 3'd5};
    seen.delete();
    prev_v = 8'h00;
    drive(3'd2, 8'd3);
    tick_cap();
    cmd_valid = 1'b0;
    tick_cap();
    for (int i = 0; i < 4; i++) begin
      drive(ins[i], 8'd1);
      tick_cap();
    end
    drive(3'd6, 8'd1);
    asserts++;
    if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin
      fails++; $display("FAIL b2b_full lvl %0d rdy %b want 4 0", fifo_level, cmd_ready);
    end
    acc = 1'b0;
    for (int i = 0; i < 60 && !acc; i++) begin
      tick_cap();
      if (cmd_ready) begin
        acc = 1'b1;
        asserts++;
        if (fifo_level !== 3'd3) begin
          fails++; $display("FAIL b2b_slot lvl %0d want 3", fifo_level);
        end
      end
    end
    asserts++;
    if (!acc) begin
      fails++; $display("FAIL b2b_accept ready never rose, want 1");
    end
    tick_cap();
    cmd_valid = 1'b0;
    for (int i = 0; i < 300 && seen.size() < 6; i++) tick_cap();
    asserts++;
    if (seen.size() != 6) begin
      fails++; $display("FAIL b2b_count got %0d doses want 6", seen.size());
    end
    for (int i = 0; i < 6 && i < seen.size(); i++) begin
      asserts++;
      if (seen[i] !== exp_q[i]) begin
        fails++; $display("FAIL b2b_order i=%0d got %h want %h", i, seen[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 40 && busy; i++) tick();
    asserts++;
    if (busy !== 1'b0 || fifo_level !== 3'd0) begin
      fails++; $display("FAIL b2b_idle busy %b lvl %0d want 0 0", busy, fifo_level);
    end
  endtask

  task automatic test_illegal();
    int nd;
    int ne;
    drive(3'd1, 8'd0);
    tick();
    drive(3'd6, 8'd2);
    tick();
    cmd_valid = 1'b0;
    asserts++;
    if (cmd_err !== 1'b1 || valve_open !== 8'h00 || busy !== 1'b0) begin
      fails++; $display("FAIL ill_err err %b v %h busy %b want 1 00 0", cmd_err, valve_open, busy);
    end
    tick();
    asserts++;
    if (cmd_err !== 1'b0 || valve_open !== 8'h40) begin
      fails++; $display("FAIL ill_next err %b v %h want 0 40", cmd_err, valve_open);
    end
    tick();
    asserts++;
    if (valve_open !== 8'h40) begin
      fails++; $display("FAIL ill_open2 got %h want 40", valve_open);
    end
    tick();
    asserts++;
    if (valve_open !== 8'h00) begin
      fails++; $display("FAIL ill_close got %h want 00", valve_open);
    end
    nd = 0;
    ne = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (dose_done) nd++;
      if (cmd_err) ne++;
    end
    asserts++;
    if (nd != 1 || ne != 0) begin
      fails++; $display("FAIL ill_pulses done %0d err %0d want 1 0", nd, ne);
    end
  endtask

  task automatic test_abort();
    int nd;
    int nv;
    drive(3'd0, 8'd10);
    tick();
    drive(3'd1, 8'd5);
    tick();
    drive(3'd2, 8'd5);
    tick();
    cmd_valid = 1'b0;
    tick();
    asserts++;
    if (valve_open !== 8'h01 || fifo_level !== 3'd2) begin
      fails++; $display("FAIL ab_pre v %h lvl %0d want 01 2", valve_open, fifo_level);
    end
    abort = 1'b1;
    drive(3'd3, 8'd3);
    #1;
    asserts++;
    if (cmd_ready !== 1'b0) begin
      fails++; $display("FAIL ab_ready got %b want 0", cmd_ready);
    end
    tick();
    abort = 1'b0;
    cmd_valid = 1'b0;
    #1;
    asserts++;
    if (valve_open !== 8'h00 || busy !== 1'b0 || fifo_level !== 3'd0) begin
      fails++; $display("FAIL ab_post v %h busy %b lvl %0d want 00 0 0", valve_open, busy, fifo_level);
    end
    nd = 0;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (dose_done || cmd_err) nd++;
      if (valve_open != 8'h00) nv++;
    end
    asserts++;
    if (nd != 0 || nv != 0) begin
      fails++; $display("FAIL ab_quiet pulses %0d open %0d want 0 0", nd, nv);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    asserts++;
    if (busy !== 1'b0 || fifo_level !== 3'd0 || valve_open !== 8'h00) begin
      fails++; $display("FAIL ab_idle busy %b lvl %0d v %h want 0 0 00", busy, fifo_level, valve_open);
    end
  endtask

  task automatic test_async_reset();
    drive(3'd5, 8'd10);
    tick();
    drive(3'd4, 8'd4);
    tick();
    cmd_valid = 1'b0;
    tick();
    asserts++;
    if (valve_open !== 8'h20) begin
      fails++; $display("FAIL ar_open got %h want 20", valve_open);
    end
    #2 rst_n = 1'b0;
    #1;
    asserts++;
    if (valve_open !== 8'h00 || busy !== 1'b0 || fifo_level !== 3'd0) begin
      fails++; $display("FAIL ar_now v %h busy %b lvl %0d want 00 0 0", valve_open, busy, fifo_level);
    end
    #3 rst_n = 1'b1;
    tick();
    tick();
    asserts++;
    if (valve_open !== 8'h00 || busy !== 1'b0 || fifo_level !== 3'd0) begin
      fails++; $display("FAIL ar_after v %h busy %b lvl %0d want 00 0 0", valve_open, busy, fifo_level);
    end
  endtask

  task automatic test_long_dose();
    logic [7:0] ev;
    int bad;
    drive(3'd7, 8'd255);
    tick();
    cmd_valid = 1'b0;
    bad = 0;
    for (int k = 1; k <= 272; k++) begin
      tick();
      ev = (k <= 255) ? 8'h80 : 8'h00;
      asserts++;
      if (valve_open !== ev || dose_done !== (k == 272)) begin
        fails++;
        $display("FAIL long k=%0d v %h done %b want %h %b", k, valve_open, dose_done, ev, k == 272);
      end
    end
    tick();
    asserts++;
    if (busy !== 1'b0 || valve_open !== 8'h00 || dose_done !== 1'b0) begin
      fails++; $display("FAIL long_end busy %b v %h done %b want 0 00 0", busy, valve_open, dose_done);
    end
  endtask

  initial begin
    asserts = 0;
    fails = 0;
    prev_v = 8'h00;
    test_reset();
    test_single_dose();
    test_back_to_back();
    test_illegal();
    test_abort();
    test_async_reset();
    test_long_dose();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
